// File: rtl/vector_execute_stage.sv
// vector_execute_stage
//   Three-lane vector execute stage. Single-cycle ALU ops complete one edge
//   after issue; multiplies share one multiplier and walk the lanes over three
//   edges, holding upstream with stall while lanes 1 and 2 are still pending.
// Ports
//   clk, reset              rising-edge clock, synchronous active-high reset
//   valid_in                instruction present on the inputs
//   srcA/srcB/extend[0:2]   lane operand A, operand B (also store data), immediate
//   ALUSrc..FlagWrite       decoded controls; ALUControl op select; WA3 dest reg
//   stall                   upstream hold request (upstream loads on ~stall)
//   valid_out               an operation completed on the last edge
//   result/writeData[0:2]   lane result and srcB copy
//   RegWriteO..PCSrcO, WA3O registered controls / destination
//   flags                   {N,Z,C,V}, taken from lane 0

module vector_execute_stage_lane #(
  parameter int N = 18
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [3:0]   op_i,
  output logic [N-1:0] y_o
);
  logic [N:0] sum_w;
  assign sum_w = {1'b0, a_i} + {1'b0, b_i};

  // Multiply (0111) is handled by the shared multiplier in the parent.
  always_comb begin
    y_o = '0;
    case (op_i)
      4'b0000: y_o = sum_w[N-1:0];
      4'b0001: y_o = a_i - b_i;
      4'b0010: y_o = a_i & b_i;
      4'b0011: y_o = a_i | b_i;
      4'b0100: y_o = a_i ^ b_i;
      4'b0101: y_o = (int'(b_i[4:0]) >= N) ? '0 : (a_i << b_i[4:0]);
      4'b0110: y_o = (int'(b_i[4:0]) >= N) ? '0 : (a_i >> b_i[4:0]);
      4'b1000: y_o = b_i;
      4'b1001: y_o = sum_w[N:1];
      default: y_o = '0;
    endcase
  end
endmodule

module vector_execute_stage #(
  parameter int N     = 18,
  parameter int LANES = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in,
  input  logic [N-1:0] srcA   [0:LANES-1],
  input  logic [N-1:0] srcB   [0:LANES-1],
  input  logic [N-1:0] extend [0:LANES-1],
  input  logic         ALUSrc,
  input  logic         RegWrite,
  input  logic         MemtoReg,
  input  logic         MemWrite,
  input  logic         PCSrc,
  input  logic         FlagWrite,
  input  logic [3:0]   ALUControl,
  input  logic [3:0]   WA3,
  output logic         stall,
  output logic         valid_out,
  output logic [N-1:0] result    [0:LANES-1],
  output logic [N-1:0] writeData [0:LANES-1],
  output logic         RegWriteO,
  output logic         MemtoRegO,
  output logic         MemWriteO,
  output logic         PCSrcO,
  output logic [3:0]   WA3O,
  output logic [3:0]   flags
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [1:0]   lane_q, lane_d;

  logic [N-1:0] opb   [0:LANES-1];
  logic [N-1:0] alu_y [0:LANES-1];

  // State captured at multiply issue; lane 0 is consumed immediately.
  logic [N-1:0] a1_q, a2_q, b1_q, b2_q, p0_q, p1_q;
  logic [N-1:0] wd_q [0:LANES-1];
  logic         rw_q, mtr_q, mw_q, pcs_q, fw_q;
  logic [3:0]   wa3_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign opb[g] = ALUSrc ? extend[g] : srcB[g];
    vector_execute_stage_lane #(.N(N)) u_lane (
      .a_i (srcA[g]),
      .b_i (opb[g]),
      .op_i(ALUControl),
      .y_o (alu_y[g])
    );
  end

  logic is_mul_op, start_mul, done_idle, done_mul;
  assign is_mul_op = (ALUControl == 4'b0111);
  assign start_mul = (state_q == IDLE) && valid_in && is_mul_op;
  assign done_idle = (state_q == IDLE) && valid_in && !is_mul_op;
  assign done_mul  = (state_q == MUL) && (lane_q == 2'd2);

  // Lane 2 is computed in the completing cycle, so upstream may advance then.
  assign stall = !reset && (start_mul || ((state_q == MUL) && (lane_q == 2'd1)));

  // Shared multiplier: lane 0 straight from the inputs at issue, then the
  // latched lane selected by the lane counter.
  logic [N-1:0] mul_a, mul_b, prod;
  always_comb begin
    mul_a = srcA[0];
    mul_b = opb[0];
    if (state_q == MUL) begin
      mul_a = (lane_q == 2'd2) ? a2_q : a1_q;
      mul_b = (lane_q == 2'd2) ? b2_q : b1_q;
    end
  end
  assign prod = mul_a * mul_b;

  // Lane 0 flags for the single-cycle path.
  logic [N:0]   sum0;
  logic         c0, v0;
  logic [3:0]   flags_idle, flags_mul;
  assign sum0 = {1'b0, srcA[0]} + {1'b0, opb[0]};
  always_comb begin
    c0 = 1'b0;
    v0 = 1'b0;
    if (ALUControl == 4'b0000) begin
      c0 = sum0[N];
      v0 = (srcA[0][N-1] == opb[0][N-1]) && (alu_y[0][N-1] != srcA[0][N-1]);
    end else if (ALUControl == 4'b0001) begin
      c0 = (srcA[0] >= opb[0]);
      v0 = (srcA[0][N-1] != opb[0][N-1]) && (alu_y[0][N-1] != srcA[0][N-1]);
    end
  end
  assign flags_idle = {alu_y[0][N-1], (alu_y[0] == '0), c0, v0};
  assign flags_mul  = {p0_q[N-1], (p0_q == '0), 2'b00};

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: if (start_mul) begin
        state_d = MUL;
        lane_d  = 2'd1;
      end
      default: begin
        if (lane_q == 2'd1) begin
          lane_d = 2'd2;
        end else begin
          state_d = IDLE;
          lane_d  = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lane_q    <= 2'd0;
      valid_out <= 1'b0;
      RegWriteO <= 1'b0;
      MemtoRegO <= 1'b0;
      MemWriteO <= 1'b0;
      PCSrcO    <= 1'b0;
      WA3O      <= 4'd0;
      flags     <= 4'd0;
      a1_q <= '0; a2_q <= '0; b1_q <= '0; b2_q <= '0; p0_q <= '0; p1_q <= '0;
      rw_q <= 1'b0; mtr_q <= 1'b0; mw_q <= 1'b0; pcs_q <= 1'b0; fw_q <= 1'b0;
      wa3_q <= 4'd0;
      for (int i = 0; i < LANES; i++) begin
        result[i]    <= '0;
        writeData[i] <= '0;
        wd_q[i]      <= '0;
      end
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      valid_out <= done_idle || done_mul;
      RegWriteO <= 1'b0;
      MemWriteO <= 1'b0;

      if (start_mul) begin
        a1_q  <= srcA[1];
        a2_q  <= srcA[2];
        b1_q  <= opb[1];
        b2_q  <= opb[2];
        p0_q  <= prod;
        rw_q  <= RegWrite;
        mtr_q <= MemtoReg;
        mw_q  <= MemWrite;
        pcs_q <= PCSrc;
        fw_q  <= FlagWrite;
        wa3_q <= WA3;
        for (int i = 0; i < LANES; i++) wd_q[i] <= srcB[i];
      end

      if ((state_q == MUL) && (lane_q == 2'd1)) p1_q <= prod;

      if (done_idle) begin
        for (int i = 0; i < LANES; i++) begin
          result[i]    <= alu_y[i];
          writeData[i] <= srcB[i];
        end
        RegWriteO <= RegWrite;
        MemtoRegO <= MemtoReg;
        MemWriteO <= MemWrite;
        PCSrcO    <= PCSrc;
        WA3O      <= WA3;
        if (FlagWrite) flags <= flags_idle;
      end

      if (done_mul) begin
        result[0] <= p0_q;
        result[1] <= p1_q;
        result[2] <= prod;
        for (int i = 0; i < LANES; i++) writeData[i] <= wd_q[i];
        RegWriteO <= rw_q;
        MemtoRegO <= mtr_q;
        MemWriteO <= mw_q;
        PCSrcO    <= pcs_q;
        WA3O      <= wa3_q;
        if (fw_q) flags <= flags_mul;
      end
    end
  end
endmodule

// File: tb/tb_vector_execute_stage.sv
// Bench for vector_execute_stage: an operation-level model (results from plain
// arithmetic, multiply completing a fixed number of edges after issue) checked
// against the DUT on every falling edge, plus literal checks on directed vectors.
module tb_vector_execute_stage;
  localparam int    N    = 18;
  localparam int    L    = 3;
  localparam longint M   = longint'(1) << N;

  logic         clk = 1'b0;
  logic         reset, valid_in;
  logic [N-1:0] srcA [0:L-1];
  logic [N-1:0] srcB [0:L-1];
  logic [N-1:0] extend [0:L-1];
  logic         ALUSrc, RegWrite, MemtoReg, MemWrite, PCSrc, FlagWrite;
  logic [3:0]   ALUControl, WA3;
  logic         stall, valid_out;
  logic [N-1:0] result [0:L-1];
  logic [N-1:0] writeData [0:L-1];
  logic         RegWriteO, MemtoRegO, MemWriteO, PCSrcO;
  logic [3:0]   WA3O, flags;

  always #5 clk = ~clk;

  vector_execute_stage #(.N(N), .LANES(L)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .srcA(srcA), .srcB(srcB), .extend(extend),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .PCSrc(PCSrc), .FlagWrite(FlagWrite), .ALUControl(ALUControl), .WA3(WA3),
    .stall(stall), .valid_out(valid_out), .result(result), .writeData(writeData),
    .RegWriteO(RegWriteO), .MemtoRegO(MemtoRegO), .MemWriteO(MemWriteO),
    .PCSrcO(PCSrcO), .WA3O(WA3O), .flags(flags)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic longint alu(input int op, input longint a, input longint b);
    longint sh;
    sh = b % 32;
    case (op)
      0: return (a + b) % M;
      1: return (a - b + M) % M;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return (sh >= N) ? 0 : ((a << sh) % M);
      6: return (sh >= N) ? 0 : (a >> sh);
      7: return (a * b) % M;
      8: return b;
      9: return (a + b) / 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] flagsm(input int op, input longint a, input longint b,
                                        input longint r);
    longint sa, sb, s;
    logic n, z, c, v;
    sa = (a >= M / 2) ? a - M : a;
    sb = (b >= M / 2) ? b - M : b;
    n = (r >= M / 2);
    z = (r == 0);
    c = 1'b0;
    v = 1'b0;
    if (op == 0) begin
      s = sa + sb;
      c = (a + b) >= M;
      v = (s > M / 2 - 1) || (s < -(M / 2));
    end else if (op == 1) begin
      s = sa - sb;
      c = (a >= b);
      v = (s > M / 2 - 1) || (s < -(M / 2));
    end
    return {n, z, c, v};
  endfunction

  function automatic longint bsel(input int i);
    return ALUSrc ? longint'(extend[i]) : longint'(srcB[i]);
  endfunction

  logic         started = 1'b0;
  int           mcnt;      // edges remaining until an issued multiply completes
  logic [N-1:0] e_res [0:L-1];
  logic [N-1:0] e_wd  [0:L-1];
  logic         e_vld, e_rw, e_mtr, e_mw, e_pcs;
  logic [3:0]   e_wa3, e_fl;
  logic [N-1:0] s_res [0:L-1];
  logic [N-1:0] s_wd  [0:L-1];
  logic         s_rw, s_mtr, s_mw, s_pcs, s_fw;
  logic [3:0]   s_wa3, s_fl;

  always @(posedge clk) begin
    if (reset) begin
      started <= 1'b1;
      mcnt    <= 0;
      e_vld <= 0; e_rw <= 0; e_mtr <= 0; e_mw <= 0; e_pcs <= 0; e_wa3 <= 0; e_fl <= 0;
      for (int i = 0; i < L; i++) begin e_res[i] <= '0; e_wd[i] <= '0; end
    end else begin
      e_vld <= 0; e_rw <= 0; e_mw <= 0;
      if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1) begin
          e_vld <= 1; e_rw <= s_rw; e_mtr <= s_mtr; e_mw <= s_mw; e_pcs <= s_pcs;
          e_wa3 <= s_wa3;
          if (s_fw) e_fl <= s_fl;
          for (int i = 0; i < L; i++) begin e_res[i] <= s_res[i]; e_wd[i] <= s_wd[i]; end
        end
      end else if (valid_in) begin
        if (ALUControl == 4'd7) begin
          mcnt <= 2;
          s_rw <= RegWrite; s_mtr <= MemtoReg; s_mw <= MemWrite; s_pcs <= PCSrc;
          s_fw <= FlagWrite; s_wa3 <= WA3;
          s_fl <= flagsm(7, srcA[0], bsel(0), alu(7, srcA[0], bsel(0)));
          for (int i = 0; i < L; i++) begin
            s_res[i] <= N'(alu(7, srcA[i], bsel(i)));
            s_wd[i]  <= srcB[i];
          end
        end else begin
          e_vld <= 1; e_rw <= RegWrite; e_mtr <= MemtoReg; e_mw <= MemWrite;
          e_pcs <= PCSrc; e_wa3 <= WA3;
          if (FlagWrite)
            e_fl <= flagsm(int'(ALUControl), srcA[0], bsel(0),
                           alu(int'(ALUControl), srcA[0], bsel(0)));
          for (int i = 0; i < L; i++) begin
            e_res[i] <= N'(alu(int'(ALUControl), srcA[i], bsel(i)));
            e_wd[i]  <= srcB[i];
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("valid_out", valid_out, e_vld);
      chk("stall", stall, !reset && ((mcnt == 0 && valid_in && ALUControl == 4'd7) || mcnt == 2));
      chk("RegWriteO", RegWriteO, e_rw);
      chk("MemWriteO", MemWriteO, e_mw);
      chk("MemtoRegO", MemtoRegO, e_mtr);
      chk("PCSrcO", PCSrcO, e_pcs);
      chk("WA3O", WA3O, e_wa3);
      chk("flags", flags, e_fl);
      for (int i = 0; i < L; i++) begin
        chk($sformatf("result%0d", i), result[i], e_res[i]);
        chk($sformatf("writeData%0d", i), writeData[i], e_wd[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int op, input logic [N-1:0] a0, a1, a2,
                       input logic [N-1:0] b0, b1, b2, input logic [N-1:0] x0, x1, x2,
                       input logic asrc, input logic fw);
    srcA[0] = a0; srcA[1] = a1; srcA[2] = a2;
    srcB[0] = b0; srcB[1] = b1; srcB[2] = b2;
    extend[0] = x0; extend[1] = x1; extend[2] = x2;
    ALUControl = 4'(op); ALUSrc = asrc; FlagWrite = fw;
    RegWrite = 1'b1; MemWrite = op[0]; MemtoReg = op[1]; PCSrc = op[2];
    WA3 = 4'(op + 3);
    valid_in = 1'b1;
  endtask

  // one edge with the current instruction, then drop valid and reach the sample point
  task automatic go();
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    issue(7, 1, 2, 3, 4, 5, 6, 0, 0, 0, 1'b0, 1'b1);   // valid during reset is ignored
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", valid_out, 0);
    chk("rst_stall", stall, 0);
    chk("rst_result0", result[0], 0);
    chk("rst_flags", flags, 0);
    reset = 1'b0; valid_in = 1'b0;

    // ADD with lane 2 wrapping
    issue(0, 5, 7, 18'h3FFFF, 3, 1, 1, 0, 0, 0, 1'b0, 1'b1);
    go();
    chk("add_valid", valid_out, 1);
    chk("add_r0", result[0], 8);
    chk("add_r1", result[1], 8);
    chk("add_r2", result[2], 0);
    chk("add_flags", flags, 4'b0000);
    @(negedge clk);
    chk("add_valid_drop", valid_out, 0);

    // SUB with immediate operand
    issue(1, 2, 9, 9, 100, 200, 300, 3, 4, 9, 1'b1, 1'b1);
    go();
    chk("sub_r0", result[0], 18'h3FFFF);
    chk("sub_r1", result[1], 5);
    chk("sub_r2", result[2], 0);
    chk("sub_wd0", writeData[0], 100);
    chk("sub_flags", flags, 4'b1000);

    // idle with write enables high: nothing completes, results hold
    RegWrite = 1'b1; MemWrite = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_valid", valid_out, 0);
    chk("idle_rw", RegWriteO, 0);
    chk("idle_mw", MemWriteO, 0);
    chk("idle_r0", result[0], 18'h3FFFF);

    // MUL with valid held high during the multiply
    issue(7, 3, 4, 18'h20000, 5, 6, 2, 0, 0, 0, 1'b0, 1'b1);
    #1 chk("mul_stall_c0", stall, 1);
    @(posedge clk); #1; @(negedge clk);
    chk("mul_stall_c1", stall, 1);
    chk("mul_valid_c1", valid_out, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("mul_stall_c2", stall, 0);
    chk("mul_valid_c2", valid_out, 0);
    go();
    chk("mul_valid_c3", valid_out, 1);
    chk("mul_r0", result[0], 15);
    chk("mul_r1", result[1], 24);
    chk("mul_r2", result[2], 0);
    chk("mul_flags", flags, 4'b0000);
    @(negedge clk);
    chk("mul_valid_c4", valid_out, 0);

    // reset on the second MUL cycle aborts it
    issue(7, 3, 4, 5, 5, 6, 7, 0, 0, 0, 1'b0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_valid", valid_out, 0);
    chk("abort_r1", result[1], 0);
    chk("abort_wa3", WA3O, 0);
    chk("abort_stall", stall, 0);
    repeat (2) @(negedge clk);
    chk("abort_no_late_valid", valid_out, 0);

    // ADD signed overflow, then carry/zero
    issue(0, 18'h1FFFF, 1, 2, 1, 1, 1, 0, 0, 0, 1'b0, 1'b1);
    go();
    chk("ovf_valid", valid_out, 1);
    chk("ovf_r0", result[0], 18'h20000);
    chk("ovf_flags", flags, 4'b1001);
    issue(0, 18'h3FFFF, 0, 0, 1, 0, 0, 0, 0, 0, 1'b0, 1'b1);
    go();
    chk("carry_flags", flags, 4'b0110);

    // SHL by 18 and AVG at the top of range; FlagWrite=0 keeps flags
    issue(5, 1, 1, 7, 18, 17, 0, 0, 0, 0, 1'b0, 1'b0);
    go();
    chk("shl_r0", result[0], 0);
    chk("shl_r1", result[1], 18'h20000);
    chk("shl_r2", result[2], 7);
    chk("shl_flags_hold", flags, 4'b0110);
    issue(9, 18'h3FFFF, 4, 1, 18'h3FFFF, 6, 0, 0, 0, 0, 1'b0, 1'b1);
    go();
    chk("avg_r0", result[0], 18'h3FFFF);
    chk("avg_r1", result[1], 5);

    // back-to-back traffic honouring stall, all opcodes
    for (int k = 0; k < 60; k++) begin
      if (!stall) begin
        issue(int'($urandom_range(0, 15)),
              N'($urandom), N'($urandom), N'($urandom),
              N'($urandom), N'($urandom_range(0, 40)), N'($urandom),
              N'($urandom_range(0, 31)), N'($urandom), N'($urandom),
              1'($urandom), 1'($urandom));
        valid_in = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vector_execute_stage.md
VECTOR_EXECUTE_STAGE -- requirements
Module: vector_execute_stage

Interface
REQ-001 Parameter: N, 18, lane data width in bits.
REQ-002 Parameter: LANES, 3, number of vector lanes; the block SHALL be fixed at 3.
REQ-003 The block SHALL use clock clk and reset reset, synchronous, active-high.
REQ-004 Ports SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- valid_in  in  1  instruction present on inputs
- srcA[0:2]  in  N each  lane operand A
- srcB[0:2]  in  N each  lane operand B / store data
- extend[0:2]  in  N each  lane immediate
- ALUSrc, RegWrite, MemtoReg, MemWrite, PCSrc, FlagWrite  in  1 each  decoded controls
- ALUControl  in  4  operation select
- WA3  in  4  destination register
- stall  out  1  upstream hold request; upstream load = ~stall
- valid_out  out  1  result registered this cycle
- result[0:2], writeData[0:2]  out  N each  lane ALU result, srcB copy
- RegWriteO, MemtoRegO, MemWriteO, PCSrcO  out  1 each  registered controls
- WA3O  out  4  registered destination
- flags  out  4  {N,Z,C,V} flag register

Function
REQ-005 Operand B per lane SHALL be extend when ALUSrc=1, else srcB.
REQ-006 ALUControl SHALL decode: 0000 A+B; 0001 A-B; 0010 A&B; 0011 A|B; 0100 A^B; 0101 A<<B[4:0]; 0110 A>>B[4:0] logical; 0111 A*B low N bits; 1000 B; 1001 (A+B)>>1 using N+1-bit sum; others 0.
REQ-007 Arithmetic SHALL be modulo 2^N; shift amount >= N SHALL yield 0.
REQ-008 FSM states SHALL be IDLE and MUL, with a 2-bit lane counter.
REQ-009 IDLE, valid_in=1, op != 0111: all lanes computed combinationally, output registers loaded at next edge, valid_out=1 for one cycle; latency 1; stall=0.
REQ-010 IDLE, valid_in=1, op=0111: operands/controls latched, lane 0 product stored, go MUL with lane=1; stall=1 in that cycle.
REQ-011 MUL: one shared multiplier SHALL compute lane counter's lane per cycle; stall=1 while lane=1, stall=0 while lane=2.
REQ-012 MUL, lane=2: lane 2 stored, output registers loaded, return IDLE; valid_out=1 the following cycle; total latency 3 edges.
REQ-013 valid_in SHALL be ignored in MUL state.
REQ-014 When no operation completes, valid_out, RegWriteO and MemWriteO SHALL be 0; result, writeData, WA3O, MemtoRegO and PCSrcO SHALL hold their values.
REQ-015 Flags SHALL derive from lane 0: N=result[N-1]; Z=(result==0); C=carry out for ADD, no-borrow (A>=B unsigned) for SUB, else 0; V=signed overflow for ADD/SUB, else 0.
REQ-016 flags SHALL update only on the completing edge of an operation with FlagWrite=1.

Reset
REQ-017 reset SHALL force state IDLE, lane 0, stall 0, valid_out 0, all result/writeData lanes 0, all control outputs 0, WA3O 0, flags 0.
REQ-018 reset during MUL SHALL abort the operation with no valid_out and no flag update.
REQ-019 reset SHALL take priority over valid_in on the same edge.

Verification
REQ-020 ADD, A={5,7,0x3FFFF}, B={3,1,1}, ALUSrc=0, FlagWrite=1 -> next cycle valid_out=1, result={8,8,0}, flags=0000, stall always 0.
REQ-021 SUB, ALUSrc=1, A={2,9,9}, extend={3,4,9} -> result={0x3FFFF,5,0}, flags N=1, Z=0, C=0, V=0.
REQ-022 MUL, A={3,4,0x20000}, B={5,6,2} -> stall=1,1,0 over three cycles, valid_out=1 exactly on fourth cycle, result={15,24,0}; valid_in held high during MUL produces no extra valid_out.
REQ-023 reset asserted on second MUL cycle -> next cycle all outputs 0, no valid_out, state IDLE accepts a new ADD normally.
REQ-024 valid_in=0 with RegWrite=1, MemWrite=1 -> valid_out, RegWriteO, MemWriteO stay 0, result unchanged; SHL by 18 -> 0; AVG {0x3FFFF,0x3FFFF} -> 0x3FFFF.
